// File: rtl/kyber_result_unpack_if.sv
// Stream bundle for kyber_result_unpack: packed multiplier beats in, natural-order coefficients out.
interface kyber_result_unpack_if #(
   parameter int COEF_W    = 12,
   parameter int N         = 256,
   parameter int PE_NUMBER = 4
);
   localparam int IDX_W = $clog2(N);

   logic                        in_valid;
   logic [COEF_W*PE_NUMBER-1:0] din;
   logic                        in_ready;
   logic                        out_valid;
   logic                        out_ready;
   logic [COEF_W-1:0]           dout_c;
   logic [IDX_W-1:0]            out_idx;
   logic                        out_last;
   logic                        done;
   logic                        err;

   modport slave (
      input  in_valid, din, out_ready,
      output in_ready, out_valid, dout_c, out_idx, out_last, done, err
   );

   modport master (
      output in_valid, din, out_ready,
      input  in_ready, out_valid, dout_c, out_idx, out_last, done, err
   );
endinterface

// File: rtl/kyber_result_unpack.sv
// Collects 64 packed four-coefficient beats into a polynomial buffer, then streams the
// coefficients out one per handshake in natural order.
module kyber_result_unpack #(
   parameter int COEF_W    = 12,
   parameter int N         = 256,
   parameter int PE_NUMBER = 4
) (
   input logic                  clk,
   input logic                  reset,
   kyber_result_unpack_if.slave bus
);
   localparam int IDX_W  = $clog2(N);
   localparam int BEAT_W = IDX_W - 2;
   localparam int DIN_W  = COEF_W * PE_NUMBER;
   localparam logic [BEAT_W-1:0] LAST_BEAT  = '1;
   localparam logic [IDX_W-1:0]  LAST_IDX   = '1;
   localparam logic [IDX_W-1:0]  PENULT_IDX = LAST_IDX - 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t            state;
   logic [BEAT_W-1:0] beat;
   logic [IDX_W-1:0]  idx;
   logic              in_ready_q;
   logic              out_valid_q;
   logic              out_last_q;
   logic              done_q;
   logic              err_q;

   logic [COEF_W-1:0] mem [N];

   logic              accept;
   logic [IDX_W-1:0]  lo_even;
   logic [IDX_W-1:0]  lo_odd;
   logic [IDX_W-1:0]  hi_even;
   logic [IDX_W-1:0]  hi_odd;
   logic [COEF_W-1:0] field3;
   logic [COEF_W-1:0] field2;
   logic [COEF_W-1:0] field1;
   logic [COEF_W-1:0] field0;

   // Beat j carries c[2j], c[2j+N/2], c[2j+1], c[2j+N/2+1] from MSB down.
   assign accept  = bus.in_valid && in_ready_q;
   assign lo_even = {1'b0, beat, 1'b0};
   assign lo_odd  = {1'b0, beat, 1'b1};
   assign hi_even = {1'b1, beat, 1'b0};
   assign hi_odd  = {1'b1, beat, 1'b1};
   assign field3  = bus.din[DIN_W-1 -: COEF_W];
   assign field2  = bus.din[DIN_W-COEF_W-1 -: COEF_W];
   assign field1  = bus.din[2*COEF_W-1 -: COEF_W];
   assign field0  = bus.din[COEF_W-1:0];

   always_ff @(posedge clk) begin
      if (accept) begin
         mem[lo_even] <= field3;
         mem[hi_even] <= field2;
         mem[lo_odd]  <= field1;
         mem[hi_odd]  <= field0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         beat        <= '0;
         idx         <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE, LOAD: begin
               if (accept) begin
                  if (beat == LAST_BEAT) begin
                     state       <= DRAIN;
                     beat        <= '0;
                     idx         <= '0;
                     in_ready_q  <= 1'b0;
                     out_valid_q <= 1'b1;
                     out_last_q  <= 1'b0;
                  end else begin
                     state <= LOAD;
                     beat  <= beat + 1'b1;
                  end
               end
            end
            DRAIN: begin
               // Beats offered while draining are dropped but remembered as a protocol error.
               if (bus.in_valid) begin
                  err_q <= 1'b1;
               end
               if (bus.out_ready) begin
                  if (idx == LAST_IDX) begin
                     state       <= IDLE;
                     idx         <= '0;
                     in_ready_q  <= 1'b1;
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                     done_q      <= 1'b1;
                  end else begin
                     idx        <= idx + 1'b1;
                     out_last_q <= (idx == PENULT_IDX);
                  end
               end
            end
            default: begin
               state       <= IDLE;
               beat        <= '0;
               idx         <= '0;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               out_last_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_last  = out_last_q;
   assign bus.out_idx   = idx;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.dout_c    = mem[idx];
endmodule

// File: tb/tb_kyber_result_unpack.sv
// Randomised bench for kyber_result_unpack against a frame-level reference model.
module tb_kyber_result_unpack;
   localparam int COEF_W = 12;
   localparam int N      = 256;
   localparam int BEATS  = N / 4;

   logic clk = 1'b0;
   logic reset;

   kyber_result_unpack_if #(.COEF_W(COEF_W), .N(N), .PE_NUMBER(4)) bus ();

   kyber_result_unpack #(.COEF_W(COEF_W), .N(N), .PE_NUMBER(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   logic [COEF_W-1:0] cur_frame [N];
   logic [COEF_W-1:0] exp_frame [N];
   logic [COEF_W-1:0] m_store   [N];
   logic [COEF_W-1:0] got_q [$];
   bit m_drain = 1'b0;
   bit m_done  = 1'b0;
   bit m_err   = 1'b0;
   int m_beats = 0;
   int m_pos   = 0;
   int done_count = 0;
   bit rdy_random = 1'b0;

   bit                prev_stall = 1'b0;
   logic [COEF_W-1:0] prev_dout;
   logic [7:0]        prev_idx;

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_vec++;
      n_err++;
      $display("[TB] FAIL %s: timed out at %0t", name, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic build_frame(input int kind);
      for (int i = 0; i < N; i++) begin
         case (kind)
            0:       cur_frame[i] = COEF_W'(i);
            1:       cur_frame[i] = COEF_W'((i * 7) % 3329);
            default: cur_frame[i] = COEF_W'($urandom_range(0, 4095));
         endcase
      end
   endtask

   function automatic logic [47:0] pack_beat(input int j);
      return {cur_frame[2*j], cur_frame[2*j+128], cur_frame[2*j+1], cur_frame[2*j+129]};
   endfunction

   // gap_mode 0: back-to-back, 1: idle cycle between beats, 2: random idle cycles
   task automatic apply_stimulus(input int kind, input int gap_mode, input int nbeats);
      int guard;
      guard = 0;
      while (!bus.in_ready && guard < 1000) begin
         tick();
         guard++;
      end
      if (!bus.in_ready) timeout_fail("in_ready_wait");
      build_frame(kind);
      for (int j = 0; j < nbeats; j++) begin
         if (gap_mode == 1 && j > 0) begin
            bus.in_valid = 1'b0;
            tick();
         end else if (gap_mode == 2) begin
            while ($urandom_range(0, 2) == 0) begin
               bus.in_valid = 1'b0;
               tick();
            end
         end
         bus.in_valid = 1'b1;
         bus.din      = pack_beat(j);
         tick();
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_done();
      int guard;
      guard = 0;
      while (!bus.done && guard < 3000) begin
         tick();
         guard++;
      end
      if (!bus.done) timeout_fail("done_wait");
   endtask

   always @(posedge clk) begin
      #1;
      bus.out_ready = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Reference model: a buffer filled from accepted beats, then read out in index order.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_drain = 1'b0;
         m_beats = 0;
         m_pos   = 0;
         m_done  = 1'b0;
         m_err   = 1'b0;
      end else begin
         m_done = 1'b0;
         if (!m_drain) begin
            if (bus.in_valid) begin
               m_store[2*m_beats]       = bus.din[47:36];
               m_store[2*m_beats + 128] = bus.din[35:24];
               m_store[2*m_beats + 1]   = bus.din[23:12];
               m_store[2*m_beats + 129] = bus.din[11:0];
               m_beats++;
               if (m_beats == BEATS) begin
                  m_drain   = 1'b1;
                  m_beats   = 0;
                  m_pos     = 0;
                  exp_frame = cur_frame;
               end
            end
         end else begin
            if (bus.in_valid) m_err = 1'b1;
            if (bus.out_ready) begin
               if (m_pos == N - 1) begin
                  m_drain = 1'b0;
                  m_pos   = 0;
                  m_done  = 1'b1;
               end else begin
                  m_pos++;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      int mism;
      check_output("in_ready", 64'(bus.in_ready), 64'(!m_drain));
      check_output("out_valid", 64'(bus.out_valid), 64'(m_drain));
      check_output("done", 64'(bus.done), 64'(m_done));
      check_output("err", 64'(bus.err), 64'(m_err));
      if (m_drain) begin
         check_output("dout_c", 64'(bus.dout_c), 64'(m_store[m_pos]));
         check_output("out_idx", 64'(bus.out_idx), 64'(m_pos));
         check_output("out_last", 64'(bus.out_last), 64'(m_pos == N - 1));
      end else begin
         check_output("out_last_idle", 64'(bus.out_last), 64'd0);
         check_output("out_idx_idle", 64'(bus.out_idx), 64'd0);
      end
      if (prev_stall && reset) begin
         check_output("stall_dout_c", 64'(bus.dout_c), 64'(prev_dout));
         check_output("stall_out_idx", 64'(bus.out_idx), 64'(prev_idx));
      end
      prev_stall = reset && bus.out_valid && !bus.out_ready;
      prev_dout  = bus.dout_c;
      prev_idx   = bus.out_idx;
      if (!reset) begin
         got_q.delete();
      end else if (bus.out_valid && bus.out_ready) begin
         got_q.push_back(bus.dout_c);
      end
      if (bus.done) done_count++;
      if (m_done) begin
         mism = 0;
         check_output("frame_len", 64'(got_q.size()), 64'(N));
         for (int i = 0; i < N; i++) begin
            if (i < got_q.size() && got_q[i] !== exp_frame[i]) mism++;
         end
         check_output("frame_data", 64'(mism), 64'd0);
         got_q.delete();
      end
   end

   initial begin
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      bus.din      = '0;
      tick();
      tick();
      tick();
      check_output("reset_in_ready", 64'(bus.in_ready), 64'd1);
      check_output("reset_out_valid", 64'(bus.out_valid), 64'd0);
      reset = 1'b1;
      tick();

      build_frame(0);
      check_output("pin_beat0", 64'(pack_beat(0)), 64'h000_080_001_081);
      check_output("pin_beat63", 64'(pack_beat(63)), 64'h07E_0FE_07F_0FF);

      $display("[TB] back-to-back ramp frame");
      apply_stimulus(0, 0, BEATS);
      wait_done();
      check_output("pin_store129", 64'(m_store[129]), 64'd129);

      $display("[TB] ramp frame with alternating gaps");
      apply_stimulus(0, 1, BEATS);
      wait_done();

      $display("[TB] random frame with random gaps and stalls");
      rdy_random = 1'b1;
      apply_stimulus(2, 2, BEATS);
      wait_done();
      rdy_random = 1'b0;

      $display("[TB] beats offered during drain");
      apply_stimulus(0, 0, BEATS);
      for (int k = 0; k < 3; k++) begin
         bus.in_valid = 1'b1;
         bus.din      = {16'($urandom), 32'($urandom)};
         tick();
      end
      bus.in_valid = 1'b0;
      check_output("err_set", 64'(bus.err), 64'd1);
      wait_done();
      check_output("err_held", 64'(bus.err), 64'd1);

      $display("[TB] reset mid-load then full frame");
      apply_stimulus(2, 0, 31);
      tick();
      reset = 1'b0;
      tick();
      tick();
      check_output("err_cleared", 64'(bus.err), 64'd0);
      check_output("reset_mid_in_ready", 64'(bus.in_ready), 64'd1);
      reset = 1'b1;
      tick();
      apply_stimulus(1, 2, BEATS);
      wait_done();
      check_output("pin_store100", 64'(m_store[100]), 64'd700);
      check_output("pin_store255", 64'(m_store[255]), 64'd1785);

      $display("[TB] two consecutive frames");
      rdy_random = 1'b1;
      apply_stimulus(2, 0, BEATS);
      wait_done();
      tick();
      apply_stimulus(0, 0, BEATS);
      wait_done();
      rdy_random = 1'b0;
      tick();
      tick();
      check_output("done_count", 64'(done_count), 64'd7);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
